// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: bus widths, the reset PC and
// the field layout of the branch and fetch-to-decode bundles.
package if_stage_pkg;

    localparam int FS_TO_DS_BUS_W = 64;
    localparam int BR_ZIP_W       = 33;
    localparam int DS_TO_ES_BUS_W = 148;

    localparam logic [31:0] IF_RESET_PC = 32'h1c00_0000;

    // br_zip = {br_taken, br_target}
    localparam int BR_TAKEN_BIT  = 32;
    localparam int BR_TARGET_MSB = 31;
    localparam int BR_TARGET_LSB = 0;

    // fs_to_ds_bus = {fs_inst, fs_pc}
    localparam int FS_INST_MSB = 63;
    localparam int FS_INST_LSB = 32;
    localparam int FS_PC_MSB   = 31;
    localparam int FS_PC_LSB   = 0;

    function automatic logic [FS_TO_DS_BUS_W-1:0] pack_fs_to_ds(
        input logic [31:0] inst,
        input logic [31:0] pc
    );
        return {inst, pc};
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC selection, PC/valid registers, SRAM
// request and a one-entry buffer that holds the fetched word under stall.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      inst_sram_en,
    output logic [3:0]                inst_sram_we,
    output logic [31:0]               inst_sram_addr,
    output logic [31:0]               inst_sram_wdata,
    input  logic [31:0]               inst_sram_rdata,
    input  logic                      ds_allowin,
    input  logic [BR_ZIP_W-1:0]       br_zip,
    output logic                      fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus
);

    logic        fs_valid_r;
    logic [31:0] fs_pc_r;
    logic [31:0] inst_buf_r;
    logic        inst_buf_valid_r;

    logic        br_taken_s;
    logic [31:0] br_target_s;
    logic [31:0] seq_pc_s;
    logic [31:0] nextpc_s;
    logic        to_fs_valid_s;
    logic        fs_ready_go_s;
    logic        fs_allowin_s;
    logic [31:0] fs_inst_s;
    logic        buf_clear_s;
    logic        buf_capture_s;

    // Next-PC selection, handshake and buffer control
    always_comb begin
        br_taken_s    = br_zip[BR_TAKEN_BIT];
        br_target_s   = br_zip[BR_TARGET_MSB:BR_TARGET_LSB];
        seq_pc_s      = fs_pc_r + 32'd4;
        nextpc_s      = seq_pc_s;
        to_fs_valid_s = ~reset;
        fs_ready_go_s = 1'b1;
        if (br_taken_s) begin
            nextpc_s = br_target_s;
        end else begin
            nextpc_s = seq_pc_s;
        end
        // A redirect always opens fetch: decode drops its own valid on br_taken.
        fs_allowin_s  = ~fs_valid_r | (fs_ready_go_s & ds_allowin) | br_taken_s;
        buf_clear_s   = (fs_to_ds_valid & ds_allowin) | br_taken_s;
        buf_capture_s = fs_valid_r & ~br_taken_s & ~ds_allowin & ~inst_buf_valid_r;
    end

    // SRAM request and fetch-to-decode outputs
    always_comb begin
        inst_sram_en    = to_fs_valid_s & fs_allowin_s;
        inst_sram_we    = 4'b0000;
        inst_sram_addr  = nextpc_s;
        inst_sram_wdata = 32'h0000_0000;
        if (inst_buf_valid_r) begin
            fs_inst_s = inst_buf_r;
        end else begin
            fs_inst_s = inst_sram_rdata;
        end
        fs_to_ds_valid  = fs_valid_r & fs_ready_go_s & ~br_taken_s;
        fs_to_ds_bus    = pack_fs_to_ds(fs_inst_s, fs_pc_r);
    end

    // PC and fetch-valid registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid_r <= 1'b0;
            fs_pc_r    <= RESET_PC - 32'd4;
        end else if (fs_allowin_s) begin
            fs_valid_r <= to_fs_valid_s;
            fs_pc_r    <= nextpc_s;
        end else begin
            fs_valid_r <= fs_valid_r;
            fs_pc_r    <= fs_pc_r;
        end
    end

    // Instruction buffer: clear wins over capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_buf_r       <= 32'h0000_0000;
            inst_buf_valid_r <= 1'b0;
        end else if (buf_clear_s) begin
            inst_buf_r       <= inst_buf_r;
            inst_buf_valid_r <= 1'b0;
        end else if (buf_capture_s) begin
            inst_buf_r       <= inst_sram_rdata;
            inst_buf_valid_r <= 1'b1;
        end else begin
            inst_buf_r       <= inst_buf_r;
            inst_buf_valid_r <= inst_buf_valid_r;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: SRAM model returns ~addr one cycle after
// each request, and a scoreboard checks every word decode accepts.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        ds_allowin;
    logic [32:0] br_zip;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;

    int vectors;
    int miscompares;
    logic [63:0] sb[$];
    logic [63:0] sb_exp;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .ds_allowin      (ds_allowin),
        .br_zip          (br_zip),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: valid data only in the cycle after a request, garbage otherwise
    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? ~inst_sram_addr : $urandom;
    end

    function automatic logic [63:0] word(input logic [31:0] pc);
        return {~pc, pc};
    endfunction

    // Scoreboard: every word accepted by decode must match the next expected one
    always @(negedge clk) begin
        #2;
        if (fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got %h want none", fs_to_ds_bus);
            end else begin
                sb_exp = sb.pop_front();
                if (fs_to_ds_bus !== sb_exp) begin
                    miscompares++;
                    $display("FAIL sb_delivery: got %h want %h", fs_to_ds_bus, sb_exp);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (inst_sram_en !== 1'b0) begin
            miscompares++; $display("FAIL rst_en: got %b want 0", inst_sram_en);
        end
        vectors++;
        if (fs_to_ds_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_valid: got %b want 0", fs_to_ds_valid);
        end
        vectors++;
        if (fs_to_ds_bus[31:0] !== 32'h1bff_fffc) begin
            miscompares++; $display("FAIL rst_pc: got %h want 1bfffffc", fs_to_ds_bus[31:0]);
        end
        vectors++;
        if (inst_sram_we !== 4'b0000 || inst_sram_wdata !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL rst_we_wdata: got %h/%h want 0/0", inst_sram_we, inst_sram_wdata);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        for (int i = 0; i < 3; i++) begin
            pc = RST_PC + 32'(4 * i);
            @(negedge clk);
            reset = 1'b0;
            sb.push_back(word(pc));
            #1;
            vectors++;
            if (inst_sram_en !== 1'b1 || inst_sram_addr !== pc) begin
                miscompares++;
                $display("FAIL stream_req: got en=%b addr=%h want en=1 addr=%h", inst_sram_en, inst_sram_addr, pc);
            end
            vectors++;
            if (i == 0 && fs_to_ds_valid !== 1'b0) begin
                miscompares++; $display("FAIL stream_first_valid: got %b want 0", fs_to_ds_valid);
            end else if (i > 0 && fs_to_ds_bus !== word(pc - 32'd4)) begin
                miscompares++;
                $display("FAIL stream_bus: got %h want %h", fs_to_ds_bus, word(pc - 32'd4));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ds_allowin = 1'b0;
            #1;
            vectors++;
            if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== word(32'h1c00_0008)) begin
                miscompares++;
                $display("FAIL stall_hold: got en=%b v=%b bus=%h want en=0 v=1 bus=%h",
                         inst_sram_en, fs_to_ds_valid, fs_to_ds_bus, word(32'h1c00_0008));
            end
        end
        @(negedge clk);
        ds_allowin = 1'b1;
        sb.push_back(word(32'h1c00_000c));
        #1;
        vectors++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_000c || fs_to_ds_bus !== word(32'h1c00_0008)) begin
            miscompares++;
            $display("FAIL stall_release: got en=%b addr=%h bus=%h want en=1 addr=1c00000c bus=%h",
                     inst_sram_en, inst_sram_addr, fs_to_ds_bus, word(32'h1c00_0008));
        end
        @(negedge clk);
        #1;
        vectors++;
        if (fs_to_ds_bus !== word(32'h1c00_000c)) begin
            miscompares++; $display("FAIL stall_next: got %h want %h", fs_to_ds_bus, word(32'h1c00_000c));
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        br_zip = {1'b1, 32'h1c00_0100};
        sb.push_back(word(32'h1c00_0100));
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'h1c00_0100 || fs_to_ds_bus[31:0] !== 32'h1c00_0010) begin
            miscompares++;
            $display("FAIL br_kill: got v=%b addr=%h pc=%h want v=0 addr=1c000100 pc=1c000010",
                     fs_to_ds_valid, inst_sram_addr, fs_to_ds_bus[31:0]);
        end
        @(negedge clk);
        br_zip = 33'd0;
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== word(32'h1c00_0100)) begin
            miscompares++;
            $display("FAIL br_target: got v=%b bus=%h want v=1 bus=%h", fs_to_ds_valid, fs_to_ds_bus, word(32'h1c00_0100));
        end
    endtask

    task automatic test_branch_stall();
        @(negedge clk);
        ds_allowin = 1'b0;
        #1;
        vectors++;
        if (inst_sram_en !== 1'b0 || fs_to_ds_bus !== word(32'h1c00_0104)) begin
            miscompares++;
            $display("FAIL brst_hold: got en=%b bus=%h want en=0 bus=%h", inst_sram_en, fs_to_ds_bus, word(32'h1c00_0104));
        end
        @(negedge clk);
        br_zip = {1'b1, 32'h1c00_0180};
        sb.push_back(word(32'h1c00_0180));
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0180) begin
            miscompares++;
            $display("FAIL brst_redirect: got v=%b en=%b addr=%h want v=0 en=1 addr=1c000180",
                     fs_to_ds_valid, inst_sram_en, inst_sram_addr);
        end
        @(negedge clk);
        br_zip = 33'd0;
        ds_allowin = 1'b1;
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== word(32'h1c00_0180)) begin
            miscompares++;
            $display("FAIL brst_newword: got v=%b bus=%h want v=1 bus=%h", fs_to_ds_valid, fs_to_ds_bus, word(32'h1c00_0180));
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        br_zip = {1'b1, 32'h1c00_0200};
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'h1c00_0200) begin
            miscompares++;
            $display("FAIL b2b_first: got v=%b addr=%h want v=0 addr=1c000200", fs_to_ds_valid, inst_sram_addr);
        end
        @(negedge clk);
        br_zip = {1'b1, 32'h1c00_0300};
        sb.push_back(word(32'h1c00_0300));
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b0 || fs_to_ds_bus[31:0] !== 32'h1c00_0200 || inst_sram_addr !== 32'h1c00_0300) begin
            miscompares++;
            $display("FAIL b2b_second: got v=%b pc=%h addr=%h want v=0 pc=1c000200 addr=1c000300",
                     fs_to_ds_valid, fs_to_ds_bus[31:0], inst_sram_addr);
        end
        @(negedge clk);
        br_zip = 33'd0;
        sb.push_back(word(32'h1c00_0304));
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== word(32'h1c00_0300)) begin
            miscompares++;
            $display("FAIL b2b_final: got v=%b bus=%h want v=1 bus=%h", fs_to_ds_valid, fs_to_ds_bus, word(32'h1c00_0300));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== word(32'h1c00_0304)) begin
            miscompares++;
            $display("FAIL mid_stream: got v=%b bus=%h want v=1 bus=%h", fs_to_ds_valid, fs_to_ds_bus, word(32'h1c00_0304));
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0 || fs_to_ds_bus[31:0] !== 32'h1bff_fffc) begin
            miscompares++;
            $display("FAIL mid_async: got v=%b en=%b pc=%h want v=0 en=0 pc=1bfffffc",
                     fs_to_ds_valid, inst_sram_en, fs_to_ds_bus[31:0]);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.push_back(word(RST_PC));
        #1;
        vectors++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC) begin
            miscompares++;
            $display("FAIL mid_restart: got en=%b addr=%h want en=1 addr=%h", inst_sram_en, inst_sram_addr, RST_PC);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== word(RST_PC)) begin
            miscompares++;
            $display("FAIL mid_first: got v=%b bus=%h want v=1 bus=%h", fs_to_ds_valid, fs_to_ds_bus, word(RST_PC));
        end
    endtask

    task automatic test_redirect_idle();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        br_zip = {1'b1, 32'h1c00_0400};
        sb.push_back(word(32'h1c00_0400));
        #1;
        vectors++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0400 || fs_to_ds_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_redirect: got en=%b addr=%h v=%b want en=1 addr=1c000400 v=0",
                     inst_sram_en, inst_sram_addr, fs_to_ds_valid);
        end
        @(negedge clk);
        br_zip = 33'd0;
        sb.push_back(word(32'h1c00_0404));
        #1;
        vectors++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== word(32'h1c00_0400)) begin
            miscompares++;
            $display("FAIL idle_target: got v=%b bus=%h want v=1 bus=%h", fs_to_ds_valid, fs_to_ds_bus, word(32'h1c00_0400));
        end
        @(negedge clk);
        #1;
        vectors++;
        if (fs_to_ds_bus !== word(32'h1c00_0404)) begin
            miscompares++; $display("FAIL idle_seq: got %h want %h", fs_to_ds_bus, word(32'h1c00_0404));
        end
        #2;
        reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        ds_allowin  = 1'b1;
        br_zip      = 33'd0;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_branch_stall();
        test_back_to_back();
        test_reset_mid();
        test_redirect_idle();
        @(negedge clk);
        #3;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
